// File: rtl/alu_operand_regs.sv
// ALU operand input registers A/B with freshness tracking for the 6502 core ALU.
// Optional select-conflict monitor enabled by defining ALU_IN_CONFLICT_EN.
module alu_operand_regs #(
  parameter int WIDTH      = 8,
  parameter int CONF_CNT_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      SB,
  input  logic [WIDTH-1:0]      DB,
  input  logic [WIDTH-1:0]      ADL,
  input  logic                  SB_ADD,
  input  logic                  O_ADD,
  input  logic                  DB_ADD,
  input  logic                  DBN_ADD,
  input  logic                  ADL_ADD,
  input  logic                  alu_consume,
  output logic [WIDTH-1:0]      a_out,
  output logic [WIDTH-1:0]      b_out,
  output logic                  a_loaded,
  output logic                  b_loaded,
  output logic                  op_ready,
  output logic                  conflict_err,
  output logic [CONF_CNT_W-1:0] conflict_cnt
);

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    A_ONLY = 2'd1,
    B_ONLY = 2'd2,
    READY  = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] a_nxt_s;
  logic [WIDTH-1:0] b_nxt_s;
  logic             a_loaded_r;
  logic             b_loaded_r;
  logic             op_ready_r;
  logic             a_load_s;
  logic             b_load_s;
  logic             a_held_s;
  logic             b_held_s;
  logic             a_fresh_s;
  logic             b_fresh_s;

  // Operand data selection with fixed priority; no select holds the register.
  always_comb begin
    a_load_s = SB_ADD | O_ADD;
    b_load_s = DB_ADD | DBN_ADD | ADL_ADD;
    a_nxt_s  = a_r;
    b_nxt_s  = b_r;
    if (SB_ADD) begin
      a_nxt_s = SB;
    end else if (O_ADD) begin
      a_nxt_s = '0;
    end else begin
      a_nxt_s = a_r;
    end
    if (DB_ADD) begin
      b_nxt_s = DB;
    end else if (DBN_ADD) begin
      b_nxt_s = ~DB;
    end else if (ADL_ADD) begin
      b_nxt_s = ADL;
    end else begin
      b_nxt_s = b_r;
    end
  end

  // Consume retires both flags before same-cycle loads are applied.
  always_comb begin
    a_held_s = 1'b0;
    b_held_s = 1'b0;
    if (alu_consume) begin
      a_held_s = 1'b0;
      b_held_s = 1'b0;
    end else begin
      a_held_s = (state_r == A_ONLY) || (state_r == READY);
      b_held_s = (state_r == B_ONLY) || (state_r == READY);
    end
    a_fresh_s = a_held_s | a_load_s;
    b_fresh_s = b_held_s | b_load_s;
    case ({a_fresh_s, b_fresh_s})
      2'b00:   state_nxt_s = EMPTY;
      2'b10:   state_nxt_s = A_ONLY;
      2'b01:   state_nxt_s = B_ONLY;
      2'b11:   state_nxt_s = READY;
      default: state_nxt_s = EMPTY;
    endcase
  end

  // Operand registers, FSM state and its decoded status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_r        <= '0;
      b_r        <= '0;
      state_r    <= EMPTY;
      a_loaded_r <= 1'b0;
      b_loaded_r <= 1'b0;
      op_ready_r <= 1'b0;
    end else begin
      a_r        <= a_nxt_s;
      b_r        <= b_nxt_s;
      state_r    <= state_nxt_s;
      a_loaded_r <= (state_nxt_s == A_ONLY) || (state_nxt_s == READY);
      b_loaded_r <= (state_nxt_s == B_ONLY) || (state_nxt_s == READY);
      op_ready_r <= (state_nxt_s == READY);
    end
  end

  assign a_out    = a_r;
  assign b_out    = b_r;
  assign a_loaded = a_loaded_r;
  assign b_loaded = b_loaded_r;
  assign op_ready = op_ready_r;

`ifdef ALU_IN_CONFLICT_EN
  localparam logic [CONF_CNT_W-1:0] CNT_MAX = {CONF_CNT_W{1'b1}};
  localparam logic [CONF_CNT_W-1:0] CNT_ONE = {{(CONF_CNT_W-1){1'b0}}, 1'b1};

  logic                  conflict_s;
  logic                  conflict_err_r;
  logic [CONF_CNT_W-1:0] conflict_cnt_r;

  function automatic logic multi_hot3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  // A and B conflicts in one cycle collapse into a single event.
  always_comb begin
    conflict_s = (SB_ADD & O_ADD) | multi_hot3({DB_ADD, DBN_ADD, ADL_ADD});
  end

  // Sticky error flag and saturating conflict counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conflict_err_r <= 1'b0;
      conflict_cnt_r <= '0;
    end else if (conflict_s) begin
      conflict_err_r <= 1'b1;
      if (conflict_cnt_r != CNT_MAX) begin
        conflict_cnt_r <= conflict_cnt_r + CNT_ONE;
      end else begin
        conflict_cnt_r <= conflict_cnt_r;
      end
    end else begin
      conflict_err_r <= conflict_err_r;
      conflict_cnt_r <= conflict_cnt_r;
    end
  end

  assign conflict_err = conflict_err_r;
  assign conflict_cnt = conflict_cnt_r;
`else
  assign conflict_err = 1'b0;
  assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_operand_regs.sv
// Directed self-checking bench for alu_operand_regs (8-bit and 16-bit instances).
module tb_alu_operand_regs;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] sb = 8'h00, db = 8'h00, adl = 8'h00;
  logic       sb_add = 1'b0, o_add = 1'b0, db_add = 1'b0, dbn_add = 1'b0, adl_add = 1'b0, consume = 1'b0;
  logic [7:0] a_out, b_out;
  logic       a_loaded, b_loaded, op_ready, conflict_err;
  logic [3:0] conflict_cnt;

  logic [15:0] sb16 = 16'h0000, db16 = 16'h0000, adl16 = 16'h0000;
  logic        sb_add16 = 1'b0, o_add16 = 1'b0, db_add16 = 1'b0, dbn_add16 = 1'b0, adl_add16 = 1'b0, consume16 = 1'b0;
  logic [15:0] a_out16, b_out16;
  logic        a_loaded16, b_loaded16, op_ready16, conflict_err16;
  logic [3:0]  conflict_cnt16;

  int total = 0;
  int bad = 0;
  int exp_cnt = 0;
  logic [3:0] exp_c;
  logic       exp_e;
  logic [7:0] exp_b;

`ifdef ALU_IN_CONFLICT_EN
  localparam bit CONF_EN = 1'b1;
`else
  localparam bit CONF_EN = 1'b0;
`endif

  alu_operand_regs #(.WIDTH(8), .CONF_CNT_W(4)) dut (
    .clk(clk), .reset(reset), .SB(sb), .DB(db), .ADL(adl),
    .SB_ADD(sb_add), .O_ADD(o_add), .DB_ADD(db_add), .DBN_ADD(dbn_add), .ADL_ADD(adl_add),
    .alu_consume(consume), .a_out(a_out), .b_out(b_out), .a_loaded(a_loaded), .b_loaded(b_loaded),
    .op_ready(op_ready), .conflict_err(conflict_err), .conflict_cnt(conflict_cnt)
  );

  alu_operand_regs #(.WIDTH(16), .CONF_CNT_W(4)) dut16 (
    .clk(clk), .reset(reset), .SB(sb16), .DB(db16), .ADL(adl16),
    .SB_ADD(sb_add16), .O_ADD(o_add16), .DB_ADD(db_add16), .DBN_ADD(dbn_add16), .ADL_ADD(adl_add16),
    .alu_consume(consume16), .a_out(a_out16), .b_out(b_out16), .a_loaded(a_loaded16), .b_loaded(b_loaded16),
    .op_ready(op_ready16), .conflict_err(conflict_err16), .conflict_cnt(conflict_cnt16)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    sb_add = 1'b0; o_add = 1'b0; db_add = 1'b0; dbn_add = 1'b0; adl_add = 1'b0; consume = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    idle();
    tick();
    tick();
    total++; if ({a_out, b_out} !== 16'h0000) begin bad++; $display("FAIL reset_data: got %h want 0000", {a_out, b_out}); end
    total++; if ({a_loaded, b_loaded, op_ready} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {a_loaded, b_loaded, op_ready}); end
    total++; if ({conflict_err, conflict_cnt} !== 5'b0) begin bad++; $display("FAIL reset_conf: got %b want 00000", {conflict_err, conflict_cnt}); end
    total++; if ({a_out16, b_out16, a_loaded16, b_loaded16, op_ready16} !== 35'b0) begin bad++; $display("FAIL reset_w16: got %h want 0", {a_out16, b_out16, a_loaded16, b_loaded16, op_ready16}); end
    reset = 1'b1;
    tick();
    total++; if ({a_loaded, b_loaded, op_ready} !== 3'b000) begin bad++; $display("FAIL release_flags: got %b want 000", {a_loaded, b_loaded, op_ready}); end
  endtask

  task automatic test_load_sequence;
    sb = 8'h5A; sb_add = 1'b1;
    tick();
    total++; if (a_out !== 8'h5A) begin bad++; $display("FAIL seq_a: got %h want 5a", a_out); end
    total++; if ({a_loaded, b_loaded, op_ready} !== 3'b100) begin bad++; $display("FAIL seq_a_only: got %b want 100", {a_loaded, b_loaded, op_ready}); end
    idle(); db = 8'h3C; dbn_add = 1'b1;
    tick();
    total++; if (b_out !== 8'hC3) begin bad++; $display("FAIL seq_b_inv: got %h want c3", b_out); end
    total++; if ({a_out, a_loaded, b_loaded, op_ready} !== {8'h5A, 3'b111}) begin bad++; $display("FAIL seq_ready: got %h/%b want 5a/111", a_out, {a_loaded, b_loaded, op_ready}); end
    idle();
  endtask

  task automatic test_consume_adl;
    adl = 8'h77; adl_add = 1'b1; consume = 1'b1;
    tick();
    total++; if (b_out !== 8'h77) begin bad++; $display("FAIL cons_adl_b: got %h want 77", b_out); end
    total++; if (a_out !== 8'h5A) begin bad++; $display("FAIL cons_adl_a: got %h want 5a", a_out); end
    total++; if ({a_loaded, b_loaded, op_ready} !== 3'b010) begin bad++; $display("FAIL cons_adl_flags: got %b want 010", {a_loaded, b_loaded, op_ready}); end
    idle();
  endtask

  task automatic test_fsm_paths;
    tick();
    total++; if ({a_out, b_out, a_loaded, b_loaded, op_ready} !== {8'h5A, 8'h77, 3'b010}) begin bad++; $display("FAIL hold: got %h %h %b", a_out, b_out, {a_loaded, b_loaded, op_ready}); end
    sb = 8'hEE; o_add = 1'b1;
    tick();
    total++; if ({a_out, a_loaded, b_loaded, op_ready} !== {8'h00, 3'b111}) begin bad++; $display("FAIL zero_load: got %h %b want 00 111", a_out, {a_loaded, b_loaded, op_ready}); end
    idle(); db = 8'h12; db_add = 1'b1;
    tick();
    total++; if ({b_out, op_ready} !== {8'h12, 1'b1}) begin bad++; $display("FAIL ready_reload: got %h %b want 12 1", b_out, op_ready); end
    idle(); consume = 1'b1;
    tick();
    total++; if ({a_out, b_out, a_loaded, b_loaded, op_ready} !== {8'h00, 8'h12, 3'b000}) begin bad++; $display("FAIL consume_only: got %h %h %b", a_out, b_out, {a_loaded, b_loaded, op_ready}); end
    tick();
    total++; if ({a_loaded, b_loaded, op_ready} !== 3'b000) begin bad++; $display("FAIL consume_empty: got %b want 000", {a_loaded, b_loaded, op_ready}); end
    sb = 8'h11; sb_add = 1'b1; db = 8'h22; db_add = 1'b1;
    tick();
    total++; if ({a_out, b_out, a_loaded, b_loaded, op_ready} !== {8'h11, 8'h22, 3'b111}) begin bad++; $display("FAIL consume_both: got %h %h %b", a_out, b_out, {a_loaded, b_loaded, op_ready}); end
    db_add = 1'b0; sb = 8'h33;
    tick();
    total++; if ({a_out, b_out, a_loaded, b_loaded, op_ready} !== {8'h33, 8'h22, 3'b100}) begin bad++; $display("FAIL consume_a: got %h %h %b", a_out, b_out, {a_loaded, b_loaded, op_ready}); end
    consume = 1'b0; sb = 8'h44;
    tick();
    total++; if ({a_out, a_loaded, b_loaded, op_ready} !== {8'h44, 3'b100}) begin bad++; $display("FAIL a_reload: got %h %b want 44 100", a_out, {a_loaded, b_loaded, op_ready}); end
    idle(); adl = 8'h55; adl_add = 1'b1;
    tick();
    total++; if ({b_out, a_loaded, b_loaded, op_ready} !== {8'h55, 3'b111}) begin bad++; $display("FAIL a_then_b: got %h %b want 55 111", b_out, {a_loaded, b_loaded, op_ready}); end
    idle();
  endtask

  task automatic test_conflict_a;
    sb = 8'hFF; sb_add = 1'b1; o_add = 1'b1;
    tick();
    exp_cnt = 1;
    exp_c = CONF_EN ? exp_cnt[3:0] : 4'd0;
    exp_e = CONF_EN;
    total++; if (a_out !== 8'hFF) begin bad++; $display("FAIL prio_a: got %h want ff", a_out); end
    total++; if ({conflict_err, conflict_cnt} !== {exp_e, exp_c}) begin bad++; $display("FAIL conflict_a: got %b/%0d want %b/%0d", conflict_err, conflict_cnt, exp_e, exp_c); end
    idle();
  endtask

  task automatic test_priority_b;
    db = 8'hA5; adl = 8'h0F; db_add = 1'b1; dbn_add = 1'b1; adl_add = 1'b1;
    tick();
    exp_cnt = 2; exp_c = CONF_EN ? exp_cnt[3:0] : 4'd0;
    total++; if (b_out !== 8'hA5) begin bad++; $display("FAIL prio_b_db: got %h want a5", b_out); end
    total++; if (conflict_cnt !== exp_c) begin bad++; $display("FAIL cnt_b3: got %0d want %0d", conflict_cnt, exp_c); end
    db_add = 1'b0;
    tick();
    exp_cnt = 3; exp_c = CONF_EN ? exp_cnt[3:0] : 4'd0;
    total++; if (b_out !== 8'h5A) begin bad++; $display("FAIL prio_b_dbn: got %h want 5a", b_out); end
    total++; if (conflict_cnt !== exp_c) begin bad++; $display("FAIL cnt_b2: got %0d want %0d", conflict_cnt, exp_c); end
    idle(); sb = 8'h01; sb_add = 1'b1; o_add = 1'b1; db = 8'h66; db_add = 1'b1; adl_add = 1'b1;
    tick();
    exp_cnt = 4; exp_c = CONF_EN ? exp_cnt[3:0] : 4'd0;
    total++; if ({a_out, b_out} !== {8'h01, 8'h66}) begin bad++; $display("FAIL prio_ab: got %h %h want 01 66", a_out, b_out); end
    total++; if (conflict_cnt !== exp_c) begin bad++; $display("FAIL cnt_ab_once: got %0d want %0d", conflict_cnt, exp_c); end
    idle();
  endtask

  task automatic test_saturate;
    adl = 8'hEE;
    for (int i = 0; i < 20; i++) begin
      exp_b = 8'(i * 7 + 3);
      db = exp_b; db_add = 1'b1; adl_add = 1'b1;
      tick();
      if (exp_cnt < 15) exp_cnt++;
      exp_c = CONF_EN ? exp_cnt[3:0] : 4'd0;
      total++; if (b_out !== exp_b) begin bad++; $display("FAIL sat_b[%0d]: got %h want %h", i, b_out, exp_b); end
      total++; if (conflict_cnt !== exp_c) begin bad++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, conflict_cnt, exp_c); end
    end
    idle();
    tick();
    exp_c = CONF_EN ? 4'd15 : 4'd0;
    exp_e = CONF_EN;
    total++; if ({conflict_err, conflict_cnt} !== {exp_e, exp_c}) begin bad++; $display("FAIL sat_hold: got %b/%0d want %b/%0d", conflict_err, conflict_cnt, exp_e, exp_c); end
  endtask

  task automatic test_async_reset;
    total++; if (op_ready !== 1'b1) begin bad++; $display("FAIL pre_reset_ready: got %b want 1", op_ready); end
    reset = 1'b0;
    #2;
    total++; if ({a_out, b_out, a_loaded, b_loaded, op_ready, conflict_err, conflict_cnt} !== 24'h0) begin bad++; $display("FAIL async_reset: got %h want 0", {a_out, b_out, a_loaded, b_loaded, op_ready, conflict_err, conflict_cnt}); end
    reset = 1'b1;
    tick();
    total++; if ({a_out, a_loaded, b_loaded, op_ready} !== 11'h0) begin bad++; $display("FAIL post_reset_empty: got %h want 0", {a_out, a_loaded, b_loaded, op_ready}); end
  endtask

  task automatic test_width16;
    sb16 = 16'h1234; sb_add16 = 1'b1;
    tick();
    total++; if ({a_out16, a_loaded16, b_loaded16, op_ready16} !== {16'h1234, 3'b100}) begin bad++; $display("FAIL w16_sb: got %h %b", a_out16, {a_loaded16, b_loaded16, op_ready16}); end
    sb_add16 = 1'b0; o_add16 = 1'b1;
    tick();
    total++; if ({a_out16, a_loaded16, b_loaded16, op_ready16} !== {16'h0000, 3'b100}) begin bad++; $display("FAIL w16_zero: got %h %b", a_out16, {a_loaded16, b_loaded16, op_ready16}); end
    o_add16 = 1'b0; db16 = 16'h00F0; dbn_add16 = 1'b1;
    tick();
    total++; if ({b_out16, op_ready16} !== {16'hFF0F, 1'b1}) begin bad++; $display("FAIL w16_dbn: got %h %b want ff0f 1", b_out16, op_ready16); end
    dbn_add16 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_sequence();
    test_consume_adl();
    test_fsm_paths();
    test_conflict_a();
    test_priority_b();
    test_saturate();
    test_async_reset();
    test_width16();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
